// File: rtl/genevr_pkg.sv
// Shared types and defaults for the packet-generator transmit scheduler.
package genevr_pkg;

   localparam int DEF_NUM_STREAMS = 4;
   localparam int DEF_CNT_WIDTH   = 32;
   localparam int DEF_GAP_WIDTH   = 16;

   // Scheduler FSM: wait for an eligible stream, present the request, wait for completion.
   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ISSUE     = 2'd1,
      ST_WAIT_DONE = 2'd2
   } genevr_state_e;

   // Stream id width: ceil(log2(n)) with a floor of one bit, for n in 1..8.
   function automatic int sid_width(input int n);
      int w;
      w = 32'sd1;
      for (int k = 1; k < 4; k++) begin
         w = ((32'sd1 << w) < n) ? (w + 32'sd1) : w;
      end
      return w;
   endfunction

endpackage

// File: rtl/genevr_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or above the pointer wins,
// otherwise the search wraps around to the lowest-numbered requester.
module genevr_rr_arbiter #(
   parameter int N         = 4,
   parameter int SID_WIDTH = 2
) (
   input  logic [N-1:0]         i_req,
   input  logic [SID_WIDTH-1:0] i_ptr,
   output logic [N-1:0]         o_grant_onehot,
   output logic [SID_WIDTH-1:0] o_grant_id,
   output logic                 o_any
);

   logic                 w_hi_found;
   logic                 w_lo_found;
   logic [SID_WIDTH-1:0] w_hi_id;
   logic [SID_WIDTH-1:0] w_lo_id;

   // Find the first requester at/after the pointer and the first overall, then pick.
   always_comb begin
      w_hi_found     = 1'b0;
      w_lo_found     = 1'b0;
      w_hi_id        = '0;
      w_lo_id        = '0;
      o_grant_onehot = '0;
      for (int i = 0; i < N; i++) begin
         w_lo_id    = (i_req[i] && !w_lo_found) ? SID_WIDTH'(i) : w_lo_id;
         w_lo_found = w_lo_found | i_req[i];
         w_hi_id    = (i_req[i] && !w_hi_found && (i >= int'(i_ptr))) ? SID_WIDTH'(i) : w_hi_id;
         w_hi_found = w_hi_found | (i_req[i] && (i >= int'(i_ptr)));
      end
      o_any      = w_lo_found;
      o_grant_id = w_hi_found ? w_hi_id : w_lo_id;
      for (int i = 0; i < N; i++) begin
         o_grant_onehot[i] = o_any && (o_grant_id == SID_WIDTH'(i));
      end
   end

endmodule

// File: rtl/genevr_tx_scheduler.sv
// Round-robin packet scheduler feeding one shared generator engine. Tracks per-stream
// packet counts, completion flags and inter-packet gap timers.
module genevr_tx_scheduler
   import genevr_pkg::*;
#(
   parameter int NUM_STREAMS = DEF_NUM_STREAMS,
   parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
   parameter int GAP_WIDTH   = DEF_GAP_WIDTH,
   parameter int SID_WIDTH   = sid_width(DEF_NUM_STREAMS)
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_STREAMS-1:0]           cfg_enable,
   input  logic [NUM_STREAMS*CNT_WIDTH-1:0] cfg_pkt_count,
   input  logic [NUM_STREAMS*GAP_WIDTH-1:0] cfg_gap,
   output logic                             gen_valid,
   output logic [SID_WIDTH-1:0]             gen_stream,
   input  logic                             gen_ready,
   input  logic                             gen_done,
   output logic [NUM_STREAMS*CNT_WIDTH-1:0] stream_sent,
   output logic [NUM_STREAMS-1:0]           stream_done,
   output logic                             busy
);

   genevr_state_e          r_state;
   logic [SID_WIDTH-1:0]   r_ptr;
   logic [NUM_STREAMS-1:0] r_grant_oh;
   logic [NUM_STREAMS-1:0] r_en_prev;
   logic [NUM_STREAMS-1:0] r_done;
   logic [CNT_WIDTH-1:0]   r_sent [NUM_STREAMS];
   logic [GAP_WIDTH-1:0]   r_gap  [NUM_STREAMS];

   logic [NUM_STREAMS-1:0] w_elig;
   logic [NUM_STREAMS-1:0] w_grant_oh;
   logic [SID_WIDTH-1:0]   w_grant_id;
   logic                   w_any;
   logic                   w_hs;
   logic                   w_cmp;

   // The grant is only taken up in IDLE; the pointer itself moves on the handshake.
   genevr_rr_arbiter #(
      .N         (NUM_STREAMS),
      .SID_WIDTH (SID_WIDTH)
   ) u_arb (
      .i_req          (w_elig),
      .i_ptr          (r_ptr),
      .o_grant_onehot (w_grant_oh),
      .o_grant_id     (w_grant_id),
      .o_any          (w_any)
   );

   assign w_hs  = (r_state == ST_ISSUE) && gen_ready;
   assign w_cmp = (r_state == ST_WAIT_DONE) && gen_done;

   // Single-request FSM with registered request, stream id and busy outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_ptr      <= '0;
         r_grant_oh <= '0;
         gen_valid  <= 1'b0;
         gen_stream <= '0;
         busy       <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  r_state    <= ST_ISSUE;
                  r_grant_oh <= w_grant_oh;
                  gen_valid  <= 1'b1;
                  gen_stream <= w_grant_id;
                  busy       <= 1'b1;
               end
            end
            ST_ISSUE: begin
               if (gen_ready) begin
                  r_state   <= ST_WAIT_DONE;
                  gen_valid <= 1'b0;
                  r_ptr     <= (gen_stream == SID_WIDTH'(NUM_STREAMS - 1)) ?
                               '0 : (gen_stream + SID_WIDTH'(1));
               end
            end
            ST_WAIT_DONE: begin
               if (gen_done) begin
                  r_state <= ST_IDLE;
                  busy    <= 1'b0;
               end
            end
            default: begin
               r_state   <= ST_IDLE;
               gen_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_STREAMS; gi++) begin : g_stream
         logic [CNT_WIDTH-1:0] w_cnt;
         logic [GAP_WIDTH-1:0] w_gap_cfg;
         logic [CNT_WIDTH-1:0] w_sent_inc;
         logic                 w_sat;
         logic                 w_arm;

         assign w_cnt      = cfg_pkt_count[gi*CNT_WIDTH +: CNT_WIDTH];
         assign w_gap_cfg  = cfg_gap[gi*GAP_WIDTH +: GAP_WIDTH];
         assign w_sent_inc = r_sent[gi] + CNT_WIDTH'(1);
         assign w_sat      = (r_sent[gi] == {CNT_WIDTH{1'b1}});
         assign w_arm      = cfg_enable[gi] && !r_en_prev[gi];
         assign w_elig[gi] = cfg_enable[gi] && !r_done[gi] && (r_gap[gi] == '0) &&
                             ((w_cnt == '0) || (r_sent[gi] < w_cnt));

         assign stream_sent[gi*CNT_WIDTH +: CNT_WIDTH] = r_sent[gi];
         assign stream_done[gi]                        = r_done[gi];

         // Per-stream arm detection, gap timer and sent/done bookkeeping.
         always_ff @(posedge clk) begin
            if (reset) begin
               r_en_prev[gi] <= 1'b0;
               r_done[gi]    <= 1'b0;
               r_sent[gi]    <= '0;
               r_gap[gi]     <= '0;
            end else begin
               r_en_prev[gi] <= cfg_enable[gi];
               if (w_arm) begin
                  r_done[gi] <= 1'b0;
                  r_sent[gi] <= '0;
                  r_gap[gi]  <= '0;
               end else begin
                  if (w_hs && r_grant_oh[gi]) begin
                     r_gap[gi] <= w_gap_cfg;
                  end else if (r_gap[gi] != '0) begin
                     r_gap[gi] <= r_gap[gi] - GAP_WIDTH'(1);
                  end
                  // Completion counts even if the stream was disabled while in flight.
                  if (w_cmp && r_grant_oh[gi]) begin
                     if (!w_sat) begin
                        r_sent[gi] <= w_sent_inc;
                     end
                     if ((w_cnt != '0) && !w_sat && (w_sent_inc == w_cnt)) begin
                        r_done[gi] <= 1'b1;
                     end
                  end
               end
            end
         end
      end
   endgenerate

endmodule
